// File: rtl/ahb_wrr_arbiter.sv
// Weighted round-robin AHB arbiter with locked-transfer hold
// and default-master parking; all outputs registered.
module ahb_wrr_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MIDX_W         = $clog2(N_MASTERS)
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [N_MASTERS-1:0]          req,
  input  logic [N_MASTERS-1:0]          lock,
  input  logic [N_MASTERS*WEIGHT_W-1:0] weight,
  input  logic                          HREADY,
  output logic [N_MASTERS-1:0]          grant,
  output logic [MIDX_W-1:0]             HMASTER,
  output logic                          HMASTLOCK,
  output logic                          grant_valid
);

  localparam logic [MIDX_W-1:0] DEF_IDX =
    MIDX_W'(DEFAULT_MASTER);
  localparam logic [MIDX_W-1:0] LAST_IDX =
    MIDX_W'(N_MASTERS - 1);
  localparam logic [WEIGHT_W-1:0] ONE_W =
    WEIGHT_W'(1);

  logic [MIDX_W-1:0]    owner_q, owner_d;
  logic [MIDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic                 gv_q, gv_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic                 mlock_q, mlock_d;

  logic                 keep;
  logic                 found;
  logic [MIDX_W-1:0]    pick;
  logic [WEIGHT_W-1:0]  pick_w;
  logic [WEIGHT_W-1:0]  pick_ew;

  assign keep = req[owner_q] && gv_q &&
                (lock[owner_q] || (credit_q > ONE_W));

  // Scan starts one past the last served master so that the
  // previous owner is the last candidate considered.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_MASTERS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx[MIDX_W-1:0];
      end
    end
  end

  assign pick_w  = weight[int'(pick)*WEIGHT_W +: WEIGHT_W];
  assign pick_ew = (pick_w == '0) ? ONE_W : pick_w;

  always_comb begin
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    credit_d = credit_q;
    gv_d     = gv_q;
    if (keep) begin
      if (!lock[owner_q]) begin
        credit_d = credit_q - ONE_W;
      end
    end else if (found) begin
      owner_d  = pick;
      rr_ptr_d = pick;
      credit_d = pick_ew;
      gv_d     = 1'b1;
    end else begin
      owner_d  = DEF_IDX;
      credit_d = '0;
      gv_d     = 1'b0;
    end
  end

  always_comb begin
    grant_d          = '0;
    grant_d[owner_d] = 1'b1;
    mlock_d          = lock[owner_d] && req[owner_d] && gv_d;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q  <= DEF_IDX;
      rr_ptr_q <= LAST_IDX;
      credit_q <= '0;
      gv_q     <= 1'b0;
      grant_q  <= N_MASTERS'(1) << DEFAULT_MASTER;
      mlock_q  <= 1'b0;
    end else if (HREADY) begin
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      gv_q     <= gv_d;
      grant_q  <= grant_d;
      mlock_q  <= mlock_d;
    end
  end

  assign grant       = grant_q;
  assign HMASTER     = owner_q;
  assign HMASTLOCK   = mlock_q;
  assign grant_valid = gv_q;

endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
// Scoreboard bench for ahb_wrr_arbiter: directed plan items
// plus randomized traffic against a behavioural model.
module tb_ahb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic         HCLK = 1'b0;
  logic         HRESET = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N*WW-1:0] weight = '0;
  logic         HREADY = 1'b1;
  logic [N-1:0] grant;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;
  logic         grant_valid;

  ahb_wrr_arbiter #(
    .N_MASTERS(N), .WEIGHT_W(WW), .DEFAULT_MASTER(0)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .lock(lock),
    .weight(weight), .HREADY(HREADY), .grant(grant),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .grant_valid(grant_valid)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [N-1:0] g;
    logic [1:0]   m;
    logic         lk;
    logic         gv;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   stepno = 0;

  int w[N] = '{4, 2, 1, 1};

  // Reference model: who owns the bus and how many granted
  // cycles remain in the current unlocked tenure.
  int owner = 0;
  int last_served = N - 1;
  int left = 0;
  bit busy = 0;
  bit held_lock = 0;

  function automatic void model(input logic [N-1:0] r,
                                input logic [N-1:0] l,
                                input bit rdy, input bit rst);
    if (rst) begin
      owner = 0; last_served = N - 1; left = 0;
      busy = 0; held_lock = 0;
      return;
    end
    if (!rdy) return;
    if (busy && r[owner] && (l[owner] || left > 1)) begin
      if (!l[owner]) left = left - 1;
    end else begin
      int nxt;
      nxt = -1;
      for (int j = 1; j <= N; j++)
        if (nxt < 0 && r[(last_served + j) % N])
          nxt = (last_served + j) % N;
      if (nxt >= 0) begin
        owner = nxt; last_served = nxt;
        left = (w[nxt] == 0) ? 1 : w[nxt];
        busy = 1;
      end else begin
        owner = 0; left = 0; busy = 0;
      end
    end
    held_lock = busy && l[owner] && r[owner];
  endfunction

  task automatic step(input logic [N-1:0] r,
                      input logic [N-1:0] l,
                      input bit rdy, input bit rst);
    exp_t e;
    @(negedge HCLK);
    req = r; lock = l; HREADY = rdy; HRESET = rst;
    for (int i = 0; i < N; i++)
      weight[i*WW +: WW] = WW'(w[i]);
    @(posedge HCLK);
    model(r, l, rdy, rst);
    e.g  = N'(1) << owner;
    e.m  = 2'(owner);
    e.lk = held_lock;
    e.gv = busy;
    sbq.push_back(e);
    stepno++;
    #1;
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d want=%0d",
               nm, stepno, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if ({grant, HMASTER, HMASTLOCK, grant_valid} !== e) begin
        failures++;
        $display("FAIL sb g=%b m=%0d lk=%b gv=%b want g=%b m=%0d lk=%b gv=%b",
                 grant, HMASTER, HMASTLOCK, grant_valid,
                 e.g, e.m, e.lk, e.gv);
      end
      checks++;
      if (!$onehot(grant)) begin
        failures++;
        $display("FAIL onehot grant=%b want one-hot", grant);
      end
    end
  end

  int seq[8] = '{0, 0, 0, 0, 1, 1, 2, 3};

  initial begin
    // reset and parking
    step(4'h0, 4'h0, 1, 1);
    step(4'h0, 4'h0, 1, 1);
    chk("rst_grant", int'(grant), 1);
    chk("rst_gv", int'(grant_valid), 0);
    chk("rst_lk", int'(HMASTLOCK), 0);
    repeat (3) step(4'h0, 4'h0, 1, 0);
    chk("park_m", int'(HMASTER), 0);
    chk("park_gv", int'(grant_valid), 0);

    // weighted share
    step(4'h0, 4'h0, 1, 1);
    for (int k = 0; k < 16; k++) begin
      step(4'hf, 4'h0, 1, 0);
      chk("wrr_seq", int'(HMASTER), seq[k % 8]);
    end

    // stall mid-tenure of master 1
    step(4'h0, 4'h0, 1, 1);
    repeat (5) step(4'hf, 4'h0, 1, 0);
    chk("stall_pre", int'(HMASTER), 1);
    repeat (5) begin
      step(4'hf, 4'h0, 0, 0);
      chk("stall_hold", int'(HMASTER), 1);
    end
    step(4'hf, 4'h0, 1, 0);
    chk("stall_rest", int'(HMASTER), 1);
    step(4'hf, 4'h0, 1, 0);
    chk("stall_next", int'(HMASTER), 2);

    // locked tenure of master 2
    step(4'h0, 4'h0, 1, 1);
    repeat (6) step(4'hf, 4'h4, 1, 0);
    for (int k = 0; k < 10; k++) begin
      step(4'hf, 4'h4, 1, 0);
      chk("lock_m", int'(HMASTER), 2);
      chk("lock_lk", int'(HMASTLOCK), 1);
    end
    step(4'hb, 4'h0, 1, 0);
    chk("unlock_m", int'(HMASTER), 3);
    chk("unlock_lk", int'(HMASTLOCK), 0);

    // zero weight, single requester
    w[3] = 0;
    repeat (6) begin
      step(4'h8, 4'h0, 1, 0);
      chk("zw_m", int'(HMASTER), 3);
      chk("zw_gv", int'(grant_valid), 1);
    end
    w[3] = 1;

    // reset mid-tenure
    step(4'h0, 4'h0, 1, 1);
    repeat (5) step(4'hf, 4'h0, 1, 0);
    chk("mrst_pre", int'(HMASTER), 1);
    step(4'hf, 4'h0, 1, 1);
    chk("mrst_m", int'(HMASTER), 0);
    chk("mrst_gv", int'(grant_valid), 0);
    step(4'hf, 4'h0, 1, 0);
    chk("mrst_first", int'(HMASTER), 0);
    chk("mrst_gv1", int'(grant_valid), 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r, l;
      if ($urandom_range(0, 49) == 0)
        w[$urandom_range(0, N-1)] = $urandom_range(0, 15);
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '1;
      l = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step(r, l, $urandom_range(0, 9) != 0,
           $urandom_range(0, 199) == 0);
    end

    begin
      int guard;
      guard = 0;
      while (sbq.size() > 0 && guard < 20) begin
        @(posedge HCLK);
        guard++;
      end
      @(posedge HCLK);
      checks++;
      if (sbq.size() != 0) begin
        failures++;
        $display("FAIL drain left=%0d want=0", sbq.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
